// File: rtl/l1d_pkg.sv
// Shared types for the L1D miss handler: widths, FSM encoding and the
// write-back buffer entry layout.
package l1d_pkg;
  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } mh_state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_entry_t;
endpackage

// File: rtl/l1d_miss_handler_wb_fifo.sv
// Circular write-back buffer with an address search port that returns the
// youngest matching data, counting a same-cycle push as youngest of all.
module wb_fifo
  import l1d_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  wb_entry_t                      i_push_entry,
  input  logic                           i_pop,
  output wb_entry_t                      o_head,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty,
  input  logic [ADDRESS_WIDTH-1:0]       i_srch_addr,
  output logic                           o_srch_hit,
  output logic [DATA_WIDTH-1:0]          o_srch_data
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_idx;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];
  // Full blocks a push even when a pop lands in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_push_entry;
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    o_srch_hit  = 1'b0;
    o_srch_data = '0;
    w_idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_mem[w_idx].addr == i_srch_addr)) begin
        o_srch_hit  = 1'b1;
        o_srch_data = r_mem[w_idx].data;
      end
    end
    if (w_push && (i_push_entry.addr == i_srch_addr)) begin
      o_srch_hit  = 1'b1;
      o_srch_data = i_push_entry.data;
    end
  end
endmodule

// File: rtl/l1d_miss_handler.sv
// L1D miss handler: buffers dirty victims, serves read-miss fills (forwarding
// from the buffer on a hit) and arbitrates both onto one memory port.
module l1d_miss_handler
  import l1d_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           evict_valid,
  output logic                           evict_ready,
  input  logic [ADDRESS_WIDTH-1:0]       evict_addr,
  input  logic [DATA_WIDTH-1:0]          evict_data,
  input  logic                           fill_req,
  input  logic [ADDRESS_WIDTH-1:0]       fill_addr,
  output logic                           fill_valid,
  output logic [DATA_WIDTH-1:0]          fill_data,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDRESS_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_gnt,
  input  logic                           mem_rvalid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [$clog2(WB_DEPTH+1)-1:0]  wb_count,
  output logic                           wb_empty
);
  mh_state_t                r_state;
  mh_state_t                w_state_nxt;
  logic                     r_fill_valid,  w_fill_valid_nxt;
  logic [DATA_WIDTH-1:0]    r_fill_data,   w_fill_data_nxt;
  logic                     r_mem_req,     w_mem_req_nxt;
  logic                     r_mem_we,      w_mem_we_nxt;
  logic [ADDRESS_WIDTH-1:0] r_mem_addr,    w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]    r_mem_wdata,   w_mem_wdata_nxt;

  wb_entry_t                w_push_entry;
  wb_entry_t                w_head;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_hit;
  logic [DATA_WIDTH-1:0]    w_hit_data;

  assign w_push_entry = '{addr: evict_addr, data: evict_data};

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_push       (evict_valid),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (wb_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .i_srch_addr  (fill_addr),
    .o_srch_hit   (w_hit),
    .o_srch_data  (w_hit_data)
  );

  assign evict_ready = !w_full;
  assign wb_empty    = w_empty;
  assign fill_valid  = r_fill_valid;
  assign fill_data   = r_fill_data;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_fill_valid <= 1'b0;
      r_fill_data  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_valid <= w_fill_valid_nxt;
      r_fill_data  <= w_fill_data_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fill_valid_nxt = 1'b0;
    w_fill_data_nxt  = r_fill_data;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_pop            = 1'b0;
    case (r_state)
      IDLE: begin
        if (fill_req) begin
          if (w_hit) begin
            w_state_nxt      = FWD;
            w_fill_valid_nxt = 1'b1;
            w_fill_data_nxt  = w_hit_data;
          end else begin
            w_state_nxt    = RD_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_we_nxt   = 1'b0;
            w_mem_addr_nxt = fill_addr;
          end
        end else if (!w_empty) begin
          w_state_nxt     = WR_REQ;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = w_head.addr;
          w_mem_wdata_nxt = w_head.data;
        end
      end
      // fill_valid is high during FWD; leaving through here keeps the
      // still-asserted fill_req from being taken as a new miss.
      FWD: w_state_nxt = IDLE;
      RD_REQ: begin
        if (mem_gnt) begin
          w_state_nxt   = RD_WAIT;
          w_mem_req_nxt = 1'b0;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          w_state_nxt      = FWD;
          w_fill_valid_nxt = 1'b1;
          w_fill_data_nxt  = mem_rdata;
        end
      end
      WR_REQ: begin
        if (mem_gnt) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_pop         = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l1d_miss_handler.sv
// Directed bench for l1d_miss_handler: reset, miss, forwarding, full/drain,
// fill-vs-drain priority and same-cycle push/fill.
module tb_l1d_miss_handler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        evict_valid = 1'b0;
  logic        evict_ready;
  logic [31:0] evict_addr = '0;
  logic [31:0] evict_data = '0;
  logic        fill_req = 1'b0;
  logic [31:0] fill_addr = '0;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  wb_count;
  logic        wb_empty;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fv     = 0;
  int n_wr     = 0;
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  always #5 clk = ~clk;

  l1d_miss_handler #(.WB_DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .wb_count    (wb_count),
    .wb_empty    (wb_empty)
  );

  // Mid-cycle monitor: fill pulses, write-request cycles and granted writes.
  always @(negedge clk) begin
    if (fill_valid) n_fv++;
    if (mem_req && mem_we) n_wr++;
    if (mem_req && mem_we && mem_gnt) begin
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    mem_gnt = 1'b1;
    while (!wb_empty && k < budget) begin
      tick();
      k++;
    end
    mem_gnt = 1'b0;
    chk("drain_empty", {31'd0, wb_empty}, 32'd1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    tick();
    evict_valid = 1'b0;
  endtask

  initial begin
    // Reset values
    #2 reset_n = 1'b0;
    #1;
    chk("rst_evict_ready", {31'd0, evict_ready}, 32'd1);
    chk("rst_fill_valid",  {31'd0, fill_valid},  32'd0);
    chk("rst_mem_req",     {31'd0, mem_req},     32'd0);
    chk("rst_wb_count",    {29'd0, wb_count},    32'd0);
    chk("rst_wb_empty",    {31'd0, wb_empty},    32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Miss to memory, with two victims to 0x200 buffered during the wait
    fill_req  = 1'b1;
    fill_addr = 32'h0000_1040;
    tick();
    chk("miss_req",  {31'd0, mem_req}, 32'd1);
    chk("miss_we",   {31'd0, mem_we},  32'd0);
    chk("miss_addr", mem_addr,         32'h0000_1040);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("miss_req_drop", {31'd0, mem_req}, 32'd0);
    push(32'h200, 32'h11);
    push(32'h200, 32'h22);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("miss_fv",    {31'd0, fill_valid}, 32'd1);
    chk("miss_data",  fill_data,           32'hDEAD_BEEF);
    chk("miss_count", {29'd0, wb_count},   32'd2);
    fill_addr = 32'h200;
    tick();
    chk("miss_fv_pulse", {31'd0, fill_valid}, 32'd0);
    chk("miss_n_fv",     n_fv,                32'd1);
    chk("miss_no_write", n_wr,                32'd0);

    // Forwarding: youngest buffered entry for 0x200
    tick();
    fill_req = 1'b0;
    chk("fwd_fv",   {31'd0, fill_valid}, 32'd1);
    chk("fwd_data", fill_data,           32'h22);
    chk("fwd_nomem", {31'd0, mem_req},   32'd0);
    drain(40);
    chk("fwd_wlog_n",  wlog_a.size(), 32'd2);
    chk("fwd_wlog0_d", wlog_d[0],     32'h11);
    chk("fwd_wlog1_d", wlog_d[1],     32'h22);
    wlog_a.delete();
    wlog_d.delete();
    tick();

    // Full buffer, blocked push, ordered drain
    push(32'h1000, 32'hA1);
    push(32'h1004, 32'hA2);
    push(32'h1008, 32'hA3);
    push(32'h100C, 32'hA4);
    chk("full_ready", {31'd0, evict_ready}, 32'd0);
    chk("full_count", {29'd0, wb_count},    32'd4);
    chk("full_head",  mem_addr,             32'h1000);
    evict_valid = 1'b1;
    evict_addr  = 32'h1010;
    evict_data  = 32'hA5;
    tick();
    chk("full_blocked", {29'd0, wb_count}, 32'd4);
    mem_gnt = 1'b1;
    tick();
    mem_gnt     = 1'b0;
    evict_valid = 1'b0;
    chk("full_pop_nopush", {29'd0, wb_count}, 32'd3);
    drain(40);
    chk("full_wlog_n", wlog_a.size(), 32'd4);
    chk("full_wlog0",  wlog_a[0],     32'h1000);
    chk("full_wlog1",  wlog_a[1],     32'h1004);
    chk("full_wlog2",  wlog_a[2],     32'h1008);
    chk("full_wlog3",  wlog_d[3],     32'hA4);
    tick();

    // Priority: fill to unmatched 0x300 beats a buffered write
    push(32'h2000, 32'hB1);
    fill_req  = 1'b1;
    fill_addr = 32'h300;
    tick();
    chk("pri_rd_first", {mem_req, mem_we}, 32'd2);
    chk("pri_rd_addr",  mem_addr,          32'h300);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77;
    tick();
    mem_rvalid = 1'b0;
    fill_req   = 1'b0;
    chk("pri_rd_data", fill_data, 32'h77);
    tick();
    tick();
    chk("pri_wr",      {mem_req, mem_we}, 32'd3);
    chk("pri_wr_data", mem_wdata,         32'hB1);
    fill_req = 1'b1;
    tick();
    chk("pri_wr_held", {mem_req, mem_we}, 32'd3);
    chk("pri_wr_addr", mem_addr,          32'h2000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("pri_wr_done", {29'd0, wb_count}, 32'd0);
    tick();
    chk("pri_rd_after", {mem_req, mem_we}, 32'd2);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h88;
    tick();
    mem_rvalid = 1'b0;
    fill_req   = 1'b0;
    chk("pri_rd2_data", fill_data, 32'h88);
    tick();

    // Same-cycle push and fill to 0x400
    evict_valid = 1'b1;
    evict_addr  = 32'h400;
    evict_data  = 32'h55;
    fill_req    = 1'b1;
    fill_addr   = 32'h400;
    tick();
    evict_valid = 1'b0;
    fill_req    = 1'b0;
    chk("same_fv",    {31'd0, fill_valid}, 32'd1);
    chk("same_data",  fill_data,           32'h55);
    chk("same_nomem", {31'd0, mem_req},    32'd0);
    chk("same_count", {29'd0, wb_count},   32'd1);
    tick();
    tick();
    chk("same_wr_addr", mem_addr,  32'h400);
    chk("same_wr_data", mem_wdata, 32'h55);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("same_drained", {29'd0, wb_count}, 32'd0);

    // Reset in the middle of a read with a buffered entry
    push(32'h500, 32'h66);
    fill_req  = 1'b1;
    fill_addr = 32'h600;
    tick();
    chk("mid_req",   {31'd0, mem_req},  32'd1);
    chk("mid_count", {29'd0, wb_count}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req",   {31'd0, mem_req},     32'd0);
    chk("mid_rst_addr",  mem_addr,             32'd0);
    chk("mid_rst_wdata", mem_wdata,            32'd0);
    chk("mid_rst_fdata", fill_data,            32'd0);
    chk("mid_rst_empty", {31'd0, wb_empty},    32'd1);
    chk("mid_rst_ready", {31'd0, evict_ready}, 32'd1);
    fill_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", {mem_req, fill_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
